// File: rtl/sprite_plotter.sv
// Sprite plotter: walks a 16x16 colour ROM row-major and writes the opaque,
// on-screen pixels to the VGA adapter through a plot/plot_ready handshake.
module sprite_plotter #(
  parameter int                  COLOUR_W         = 3,
  parameter int                  SCREEN_W         = 160,
  parameter int                  SCREEN_H         = 120,
  parameter logic [COLOUR_W-1:0] TRANSPARENT      = '0,
  parameter bit                  SKIP_TRANSPARENT = 1'b1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [7:0]          origin_x,
  input  logic [6:0]          origin_y,
  output logic [7:0]          rom_address,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [7:0]          vga_x,
  output logic [6:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                plot,
  input  logic                plot_ready,
  output logic                busy,
  output logic                done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECIDE,
    S_PLOT,
    S_ADVANCE,
    S_DONE
  } state_t;

  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

  state_t      state;
  state_t      state_n;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [7:0]  org_x;
  logic [6:0]  org_y;
  logic [8:0]  sum_x;
  logic [7:0]  sum_y;
  logic [7:0]  next_addr;
  logic        clipped;
  logic        clear;
  logic        last;

  // Widened sums so an origin near the edge clips instead of wrapping.
  assign sum_x     = {1'b0, org_x} + {5'd0, col};
  assign sum_y     = {1'b0, org_y} + {4'd0, row};
  assign next_addr = {row, col} + 8'd1;
  assign clipped   = (sum_x >= X_LIM) || (sum_y >= Y_LIM);
  assign clear     = SKIP_TRANSPARENT && (rom_data == TRANSPARENT);
  assign last      = (col == 4'hf) && (row == 4'hf);

  assign plot = (state == S_PLOT);
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:    if (start) state_n = S_FETCH;
      S_FETCH:   state_n = S_WAIT;
      S_WAIT:    state_n = S_DECIDE;
      S_DECIDE:  state_n = (clipped || clear) ? S_ADVANCE : S_PLOT;
      S_PLOT:    if (plot_ready) state_n = S_ADVANCE;
      S_ADVANCE: state_n = last ? S_DONE : S_FETCH;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col         <= '0;
      row         <= '0;
      org_x       <= '0;
      org_y       <= '0;
      rom_address <= '0;
      vga_x       <= '0;
      vga_y       <= '0;
      vga_colour  <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            org_x       <= origin_x;
            org_y       <= origin_y;
            col         <= '0;
            row         <= '0;
            rom_address <= '0;
          end
        end
        S_DECIDE: begin
          vga_colour <= rom_data;
          vga_x      <= sum_x[7:0];
          vga_y      <= sum_y[6:0];
        end
        S_ADVANCE: begin
          {row, col} <= next_addr;
          // Address stays on the last pixel once the sprite is finished.
          if (!last) rom_address <= next_addr;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_plotter.sv
// Bench for sprite_plotter: directed sprites with a queue of expected
// pixels, drained by an independent monitor on accepted plots.
module tb_sprite_plotter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] origin_x = '0;
  logic [6:0] origin_y = '0;
  logic [7:0] rom_address;
  logic [2:0] rom_data;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       plot_ready = 1'b1;
  logic       busy;
  logic       done;

  logic [2:0]  rom [256];
  logic [17:0] exp_q [$];
  logic [17:0] mon_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nplots = 0;

  sprite_plotter dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .origin_x(origin_x),
    .origin_y(origin_y),
    .rom_address(rom_address),
    .rom_data(rom_data),
    .vga_x(vga_x),
    .vga_y(vga_y),
    .vga_colour(vga_colour),
    .plot(plot),
    .plot_ready(plot_ready),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom[rom_address];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && plot && plot_ready) begin
      nplots++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_plot actual=(%0d,%0d,%0d) expected=none",
                 vga_x, vga_y, vga_colour);
      end else begin
        mon_e = exp_q.pop_front();
        chk("plot_pixel", {vga_x, vga_y, vga_colour}, mon_e);
      end
      chk("plot_onscreen", (vga_x < 8'd160) && (vga_y < 7'd120), 1);
    end
  end

  task automatic fill_opaque();
    for (int a = 0; a < 256; a++) rom[a] = 3'(a) | 3'b001;
  endtask

  task automatic push_sprite(input int ox, input int oy);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        int x;
        int y;
        logic [2:0] k;
        x = ox + c;
        y = oy + r;
        k = rom[r * 16 + c];
        if (x < 160 && y < 120 && k != 3'b000)
          exp_q.push_back({8'(x), 7'(y), k});
      end
  endtask

  task automatic do_start(input int ox, input int oy, output int t0);
    @(posedge clk);
    #1;
    origin_x = 8'(ox);
    origin_y = 7'(oy);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic after_done();
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int t0;
    int at;
    int n0;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_plot", plot, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {rom_address, vga_x, vga_y, vga_colour}, 0);
    #21 resetn = 1'b1;
    repeat (3) @(posedge clk);

    // T1: opaque sprite at (10,20), ready always high
    fill_opaque();
    push_sprite(10, 20);
    n0 = nplots;
    do_start(10, 20, t0);
    wait_done(2000, at);
    chk("t1_latency", at - t0, 1281);
    chk("t1_count", nplots - n0, 256);
    chk("t1_queue_empty", exp_q.size(), 0);
    after_done();

    // T2: single opaque pixel at address 17
    for (int a = 0; a < 256; a++) rom[a] = 3'b000;
    rom[17] = 3'b101;
    push_sprite(0, 0);
    n0 = nplots;
    do_start(0, 0, t0);
    wait_done(2000, at);
    chk("t2_latency", at - t0, 1026);
    chk("t2_count", nplots - n0, 1);
    after_done();

    // T3: clipping at (150,110)
    fill_opaque();
    push_sprite(150, 110);
    n0 = nplots;
    do_start(150, 110, t0);
    wait_done(2000, at);
    chk("t3_latency", at - t0, 1125);
    chk("t3_count", nplots - n0, 100);
    chk("t3_queue_empty", exp_q.size(), 0);
    after_done();

    // T4: back-pressure on pixel 3
    push_sprite(0, 0);
    n0 = nplots;
    do_start(0, 0, t0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rom_address == 8'd3) break;
    end
    #1 plot_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (plot) break;
    end
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      chk("t4_stall_plot", plot, 1);
      chk("t4_stall_hold", {vga_x, vga_y, vga_colour},
          {8'd3, 7'd0, rom[3]});
    end
    @(posedge clk);
    #1 plot_ready = 1'b1;
    wait_done(2000, at);
    chk("t4_latency", at - t0, 1288);
    chk("t4_count", nplots - n0, 256);
    after_done();

    // T5: start mid-sprite and in DONE ignored, start after DONE accepted
    push_sprite(5, 6);
    do_start(5, 6, t0);
    repeat (100) @(posedge clk);
    #1;
    origin_x = 8'd99;
    origin_y = 7'd99;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(2000, at);
    chk("t5_latency", at - t0, 1281);
    chk("t5_queue_empty", exp_q.size(), 0);
    push_sprite(30, 40);
    #1;
    origin_x = 8'd30;
    origin_y = 7'd40;
    start = 1'b1;
    @(negedge clk);
    chk("t5_done_start_ignored", busy, 0);
    t0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("t5_restart_busy", busy, 1);
    wait_done(2000, at);
    chk("t5_restart_latency", at - t0, 1281);
    chk("t5_restart_queue", exp_q.size(), 0);
    after_done();

    // T6: reset while pixel 40 is being plotted
    for (int k = 0; k < 41; k++)
      exp_q.push_back({8'(k % 16), 7'(k / 16), rom[k]});
    do_start(0, 0, t0);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (plot && vga_x == 8'd8 && vga_y == 7'd2) break;
    end
    #1 resetn = 1'b0;
    #1;
    chk("t6_rst_plot", plot, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_outs", {rom_address, vga_x, vga_y, vga_colour}, 0);
    chk("t6_queue_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    n0 = nplots;
    repeat (50) @(negedge clk);
    chk("t6_no_plot_after", nplots - n0, 0);
    chk("t6_idle_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
Name: sprite_plotter

Overview:
Consumes a 16x16 sprite stored in a synchronous colour ROM and writes its pixels to the VGA frame-buffer adapter at a requested screen origin. A host FSM pulses start with an origin. The block walks sprite offsets row-major, fetches each colour, and drives vga_x/vga_y/vga_colour with a plot/plot_ready handshake. It skips transparent and off-screen pixels and pulses done when finished.

Parameters:
COLOUR_W, 3, bits per pixel colour (ROM data width and vga_colour width)
SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped
TRANSPARENT, 3'b000, colour value treated as transparent
SKIP_TRANSPARENT, 1, 1 = suppress plot for TRANSPARENT pixels; 0 = plot every pixel

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
origin_x  in  8  screen x of sprite offset (0,0); latched on accepted start
origin_y  in  7  screen y of sprite offset (0,0); latched on accepted start
rom_address  out  8  sprite ROM address = {row[3:0], col[3:0]} (= col + 16*row)
rom_data  in  COLOUR_W  ROM read data, valid exactly 1 cycle after rom_address
vga_x  out  8  pixel x = origin_x + col (9-bit internal sum)
vga_y  out  7  pixel y = origin_y + row (8-bit internal sum)
vga_colour  out  COLOUR_W  pixel colour
plot  out  1  pixel write request; vga_* stable while asserted
plot_ready  in  1  adapter accepts the pixel in a cycle with plot & plot_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last pixel is resolved

Behaviour:
- Reset (async, resetn=0): state=IDLE; col=row=0; rom_address=0, vga_x=0, vga_y=0, vga_colour=0, plot=0, busy=0, done=0; latched origin cleared. Reset mid-sprite abandons the sprite with no further plot.
- States: IDLE, FETCH, WAIT, DECIDE, PLOT, ADVANCE, DONE.
- IDLE: on start=1, latch origin, col=row=0, go to FETCH. start in any other state is ignored; no queueing.
- FETCH: drive rom_address={row,col}, go to WAIT. rom_address holds until the next FETCH.
- WAIT: ROM latency cycle, go to DECIDE.
- DECIDE: capture rom_data into vga_colour and load vga_x/vga_y from the sums.
  - Go to ADVANCE with no plot if either holds:
    - clipped: x sum >= SCREEN_W or y sum >= SCREEN_H; 9/8-bit sums, so no wrap-around.
    - transparent: SKIP_TRANSPARENT=1 and rom_data==TRANSPARENT.
  - Otherwise go to PLOT.
- PLOT: plot=1. Hold vga_x, vga_y and vga_colour constant until plot&plot_ready, then plot=0 on the next cycle and go to ADVANCE. plot_ready may already be high on entry, giving a 1-cycle PLOT. There is no timeout.
- ADVANCE: if col==15 then col=0 and row=row+1, else col=col+1.
  - After col==15 with row==15, go to DONE.
  - Otherwise go to FETCH.
- DONE: done=1 for exactly one cycle, then go to IDLE. A start in the DONE cycle is ignored. A start in the following IDLE cycle is accepted.
- Latency:
  - Minimum per pixel: 5 cycles (FETCH, WAIT, DECIDE, PLOT, ADVANCE) with plot_ready tied high.
  - Skipped pixel: 4 cycles.
  - Full sprite, nothing skipped, ready high: 256*5 + 1 (DONE) = 1281 cycles from the cycle after start to the done pulse.
- Exactly 256 pixel visits per sprite, in row-major order. Each visible, non-transparent pixel produces exactly one accepted plot.

Test Plan:
- Ready tied high, ROM[a]=a[2:0]|1 (no transparent), origin (10,20), start -> 256 plots in order (10,20),(11,20)...(25,35); colour matches ROM; done 1281 cycles after the start cycle; busy low after.
- SKIP_TRANSPARENT=1, ROM all 0 except addr 17=3'b101, origin (0,0) -> exactly one plot at (1,1) colour 5; done still pulses.
- Origin (150,110), opaque ROM -> plots only for col<=9 and row<=9 (100 plots); no x>=160 or y>=120 ever appears on vga_* with plot=1.
- plot_ready low for 7 cycles on pixel 3 -> plot and vga_* held steady all 7 cycles; one acceptance; next pixel resumes; total plots still 256.
- start pulsed again mid-sprite, and again in the DONE cycle -> both ignored; start one cycle after done -> new sprite begins.
- resetn asserted at pixel 40 with plot high -> outputs go to reset values immediately; after release no plot until a new start.
